// File: rtl/pong_game_ctrl_if.sv
// Control and position bundle between the Pong game sequencer and its consumers.
// The master drives player/strobe inputs; the slave (sequencer) returns game state.
interface pong_game_ctrl_if;
  logic        frame_tick;
  logic        p1_up;
  logic        p1_down;
  logic        p2_up;
  logic        p2_down;
  logic        serve;
  logic [11:0] ball_x;
  logic [11:0] ball_y;
  logic [11:0] p1_y;
  logic [11:0] p2_y;
  logic [3:0]  score1;
  logic [3:0]  score2;
  logic [1:0]  state;

  modport master (
    output frame_tick, p1_up, p1_down, p2_up, p2_down, serve,
    input  ball_x, ball_y, p1_y, p2_y, score1, score2, state
  );

  modport slave (
    input  frame_tick, p1_up, p1_down, p2_up, p2_down, serve,
    output ball_x, ball_y, p1_y, p2_y, score1, score2, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Per-frame Pong game sequencer: ball motion, paddle motion, collisions and scoring.
// All state advances on frame_tick except serve-driven transitions.
module pong_game_ctrl #(
  parameter int BALL_SIZE     = 5,
  parameter int PLAYER_HEIGHT = 60,
  parameter int PLAYER_WIDTH  = 12,
  parameter int PLAYER_1_X    = 24,
  parameter int PLAYER_2_X    = 615,
  parameter int PLAYER_STEP   = 4,
  parameter int BALL_STEP     = 2,
  parameter int WIN_SCORE     = 9,
  parameter int PAUSE_FRAMES  = 60
) (
  input  logic             CLOCK_25,
  input  logic             RESET_N,
  pong_game_ctrl_if.slave  bus
);

  localparam int FRAME_W = 640;
  localparam int FRAME_H = 480;
  localparam int PW      = $clog2(PAUSE_FRAMES);

  localparam logic [11:0] PSTEP      = 12'(PLAYER_STEP);
  localparam logic [11:0] BSTEP      = 12'(BALL_STEP);
  localparam logic [11:0] BSIZE      = 12'(BALL_SIZE);
  localparam logic [11:0] PHEIGHT    = 12'(PLAYER_HEIGHT);
  localparam logic [11:0] BALL_X0    = 12'((FRAME_W - BALL_SIZE - 1) / 2);
  localparam logic [11:0] BALL_Y0    = 12'((FRAME_H - BALL_SIZE - 1) / 2);
  localparam logic [11:0] PAD_Y0     = 12'((FRAME_H - PLAYER_HEIGHT) / 2);
  localparam logic [11:0] PAD_MAX    = 12'(FRAME_H - 1 - PLAYER_HEIGHT);
  localparam logic [11:0] BALL_Y_MAX = 12'(FRAME_H - 1 - BALL_SIZE);
  localparam logic [11:0] BALL_X_MAX = 12'(FRAME_W - 1 - BALL_SIZE);
  localparam logic [11:0] P1_HIT_X   = 12'(PLAYER_1_X + PLAYER_WIDTH + 1);
  localparam logic [11:0] P2_HIT_X   = 12'(PLAYER_2_X - BALL_SIZE - 1);
  localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PLAY  = 2'b01,
    POINT = 2'b10,
    OVER  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic [11:0]   p1_q, p1_d, p2_q, p2_d;
  logic [3:0]    score1_q, score1_d, score2_q, score2_d;
  logic          dx_right_q, dx_right_d, dy_down_q, dy_down_d;
  logic [PW-1:0] pause_q, pause_d;
  logic          ov1, ov2, goal_left, goal_right;

  function automatic logic [11:0] move_paddle(input logic [11:0] y,
                                              input logic up, input logic dn);
    logic [11:0] r;
    r = y;
    if (up && !dn)      r = (y >= PSTEP) ? y - PSTEP : 12'd0;
    else if (dn && !up) r = (y + PSTEP >= PAD_MAX) ? PAD_MAX : y + PSTEP;
    return r;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN) ? s : s + 4'd1;
  endfunction

  // Collisions use the paddle positions registered before this tick.
  assign ov1 = (ball_y_q + BSIZE >= p1_q) && (ball_y_q <= p1_q + PHEIGHT);
  assign ov2 = (ball_y_q + BSIZE >= p2_q) && (ball_y_q <= p2_q + PHEIGHT);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    dx_right_d = dx_right_q;
    dy_down_d  = dy_down_q;
    pause_d    = pause_q;
    goal_left  = 1'b0;
    goal_right = 1'b0;

    if (bus.frame_tick && state_q != OVER) begin
      p1_d = move_paddle(p1_q, bus.p1_up, bus.p1_down);
      p2_d = move_paddle(p2_q, bus.p2_up, bus.p2_down);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.serve) begin
          state_d    = PLAY;
          dx_right_d = 1'b1;
          dy_down_d  = 1'b1;
        end
      end

      PLAY: begin
        if (bus.frame_tick) begin
          if (dy_down_q) begin
            if (ball_y_q + BSTEP >= BALL_Y_MAX) begin
              ball_y_d  = BALL_Y_MAX;
              dy_down_d = 1'b0;
            end else begin
              ball_y_d = ball_y_q + BSTEP;
            end
          end else if (ball_y_q <= BSTEP) begin
            ball_y_d  = 12'd0;
            dy_down_d = 1'b1;
          end else begin
            ball_y_d = ball_y_q - BSTEP;
          end

          // A paddle hit takes priority over a goal on the same tick.
          if (!dx_right_q) begin
            if (ball_x_q >= P1_HIT_X && ball_x_q - BSTEP <= P1_HIT_X - 12'd1 && ov1) begin
              ball_x_d   = P1_HIT_X;
              dx_right_d = 1'b1;
            end else if (ball_x_q <= BSTEP) begin
              goal_left = 1'b1;
            end else begin
              ball_x_d = ball_x_q - BSTEP;
            end
          end else begin
            if (ball_x_q <= P2_HIT_X && ball_x_q + BSTEP >= P2_HIT_X + 12'd1 && ov2) begin
              ball_x_d   = P2_HIT_X;
              dx_right_d = 1'b0;
            end else if (ball_x_q + BSTEP >= BALL_X_MAX) begin
              goal_right = 1'b1;
            end else begin
              ball_x_d = ball_x_q + BSTEP;
            end
          end

          if (goal_left || goal_right) begin
            ball_x_d   = BALL_X0;
            ball_y_d   = BALL_Y0;
            pause_d    = '0;
            dx_right_d = goal_right;
            if (goal_left) score2_d = sat_inc(score2_q);
            else           score1_d = sat_inc(score1_q);
            state_d = (score1_d == WIN || score2_d == WIN) ? OVER : POINT;
          end
        end
      end

      POINT: begin
        if (bus.frame_tick) begin
          if (pause_q == PAUSE_LAST) begin
            pause_d = '0;
            state_d = PLAY;
          end else begin
            pause_d = pause_q + 1'b1;
          end
        end
      end

      OVER: begin
        if (bus.serve) begin
          state_d    = IDLE;
          score1_d   = 4'd0;
          score2_d   = 4'd0;
          p1_d       = PAD_Y0;
          p2_d       = PAD_Y0;
          ball_x_d   = BALL_X0;
          ball_y_d   = BALL_Y0;
          dx_right_d = 1'b1;
          dy_down_d  = 1'b1;
          pause_d    = '0;
        end
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_25) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      ball_x_q   <= BALL_X0;
      ball_y_q   <= BALL_Y0;
      p1_q       <= PAD_Y0;
      p2_q       <= PAD_Y0;
      score1_q   <= 4'd0;
      score2_q   <= 4'd0;
      dx_right_q <= 1'b1;
      dy_down_q  <= 1'b1;
      pause_q    <= '0;
    end else begin
      state_q    <= state_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      dx_right_q <= dx_right_d;
      dy_down_q  <= dy_down_d;
      pause_q    <= pause_d;
    end
  end

  assign bus.ball_x = ball_x_q;
  assign bus.ball_y = ball_y_q;
  assign bus.p1_y   = p1_q;
  assign bus.p2_y   = p2_q;
  assign bus.score1 = score1_q;
  assign bus.score2 = score2_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: a vector table for the opening frames, then
// hand-traced rallies for wall bounces, paddle hits, goals, pause, game over and reset.
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  pong_game_ctrl_if bus ();

  pong_game_ctrl dut (
    .CLOCK_25 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // btn = {p1_up, p1_down, p2_up, p2_down}
  typedef struct {
    logic        serve;
    logic        tick;
    logic [3:0]  btn;
    logic [11:0] bx, by, p1, p2;
    logic [3:0]  s1, s2;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [11:0] bx, input logic [11:0] by,
                           input logic [11:0] p1, input logic [11:0] p2,
                           input logic [3:0] s1, input logic [3:0] s2,
                           input logic [1:0] st);
    check({tag, ".ball_x"}, bus.ball_x, bx);
    check({tag, ".ball_y"}, bus.ball_y, by);
    check({tag, ".p1_y"},   bus.p1_y,   p1);
    check({tag, ".p2_y"},   bus.p2_y,   p2);
    check({tag, ".score1"}, {8'd0, bus.score1}, {8'd0, s1});
    check({tag, ".score2"}, {8'd0, bus.score2}, {8'd0, s2});
    check({tag, ".state"},  {10'd0, bus.state}, {10'd0, st});
  endtask

  task automatic cycle(input logic sv, input logic tk, input logic [3:0] b);
    @(negedge clk);
    bus.serve      = sv;
    bus.frame_tick = tk;
    {bus.p1_up, bus.p1_down, bus.p2_up, bus.p2_down} = b;
    @(posedge clk);
    #1;
    bus.serve      = 1'b0;
    bus.frame_tick = 1'b0;
    {bus.p1_up, bus.p1_down, bus.p2_up, bus.p2_down} = 4'b0000;
  endtask

  task automatic ticks(input int n, input logic [3:0] b);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bus.serve      = 1'b0;
    bus.frame_tick = 1'b0;
    {bus.p1_up, bus.p1_down, bus.p2_up, bus.p2_down} = 4'b0000;

    vecs[0] = '{1'b0, 1'b0, 4'b0000, 12'd317, 12'd237, 12'd210, 12'd210, 4'd0, 4'd0, 2'd0};
    vecs[1] = '{1'b0, 1'b1, 4'b1000, 12'd317, 12'd237, 12'd206, 12'd210, 4'd0, 4'd0, 2'd0};
    vecs[2] = '{1'b0, 1'b1, 4'b0001, 12'd317, 12'd237, 12'd206, 12'd214, 4'd0, 4'd0, 2'd0};
    vecs[3] = '{1'b0, 1'b1, 4'b1111, 12'd317, 12'd237, 12'd206, 12'd214, 4'd0, 4'd0, 2'd0};
    vecs[4] = '{1'b0, 1'b1, 4'b0110, 12'd317, 12'd237, 12'd210, 12'd210, 4'd0, 4'd0, 2'd0};
    vecs[5] = '{1'b1, 1'b1, 4'b1000, 12'd317, 12'd237, 12'd206, 12'd210, 4'd0, 4'd0, 2'd1};
    vecs[6] = '{1'b0, 1'b0, 4'b0000, 12'd317, 12'd237, 12'd206, 12'd210, 4'd0, 4'd0, 2'd1};
    vecs[7] = '{1'b0, 1'b1, 4'b0000, 12'd319, 12'd239, 12'd206, 12'd210, 4'd0, 4'd0, 2'd1};
    vecs[8] = '{1'b1, 1'b1, 4'b0000, 12'd321, 12'd241, 12'd206, 12'd210, 4'd0, 4'd0, 2'd1};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset", 12'd317, 12'd237, 12'd210, 12'd210, 4'd0, 4'd0, 2'd0);

    // Opening: paddles in IDLE, serve+tick, first ball moves.
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].serve, vecs[i].tick, vecs[i].btn);
      check_all($sformatf("vec%0d", i), vecs[i].bx, vecs[i].by, vecs[i].p1, vecs[i].p2,
                vecs[i].s1, vecs[i].s2, vecs[i].st);
    end

    // Rally A: down-right, bottom bounce, misses p2 at 210, right goal.
    ticks(9, 4'b0000);
    check_all("a_k11", 12'd339, 12'd259, 12'd206, 12'd210, 4'd0, 4'd0, 2'd1);
    ticks(107, 4'b0000);
    check_all("a_k118", 12'd553, 12'd473, 12'd206, 12'd210, 4'd0, 4'd0, 2'd1);
    ticks(1, 4'b0000);
    check_all("a_bottom", 12'd555, 12'd474, 12'd206, 12'd210, 4'd0, 4'd0, 2'd1);
    ticks(1, 4'b0000);
    check_all("a_up", 12'd557, 12'd472, 12'd206, 12'd210, 4'd0, 4'd0, 2'd1);
    ticks(38, 4'b0000);
    check_all("a_k158", 12'd633, 12'd396, 12'd206, 12'd210, 4'd0, 4'd0, 2'd1);
    ticks(1, 4'b0000);
    check_all("a_goal", 12'd317, 12'd237, 12'd206, 12'd210, 4'd1, 4'd0, 2'd2);
    for (int i = 0; i < 59; i++) cycle(i == 30, 1'b1, 4'b0000);
    check_all("a_pause59", 12'd317, 12'd237, 12'd206, 12'd210, 4'd1, 4'd0, 2'd2);
    ticks(1, 4'b0000);
    check_all("a_pause60", 12'd317, 12'd237, 12'd206, 12'd210, 4'd1, 4'd0, 2'd1);
    ticks(1, 4'b0000);
    check_all("a_resume", 12'd319, 12'd235, 12'd206, 12'd210, 4'd1, 4'd0, 2'd1);

    // Rally B: paddle saturation, p2 hit, p1 miss and left goal, then p1 hit.
    do_reset();
    check_all("b_reset", 12'd317, 12'd237, 12'd210, 12'd210, 4'd0, 4'd0, 2'd0);
    ticks(52, 4'b1001);
    check_all("b_pad52", 12'd317, 12'd237, 12'd2, 12'd418, 4'd0, 4'd0, 2'd0);
    ticks(1, 4'b1001);
    check_all("b_pad53", 12'd317, 12'd237, 12'd0, 12'd419, 4'd0, 4'd0, 2'd0);
    ticks(1, 4'b1001);
    check_all("b_padsat", 12'd317, 12'd237, 12'd0, 12'd419, 4'd0, 4'd0, 2'd0);
    ticks(1, 4'b1111);
    check_all("b_both", 12'd317, 12'd237, 12'd0, 12'd419, 4'd0, 4'd0, 2'd0);
    cycle(1'b1, 1'b0, 4'b0000);
    check_all("b_serve", 12'd317, 12'd237, 12'd0, 12'd419, 4'd0, 4'd0, 2'd1);
    ticks(146, 4'b0000);
    check_all("b_k146", 12'd609, 12'd420, 12'd0, 12'd419, 4'd0, 4'd0, 2'd1);
    ticks(1, 4'b0000);
    check_all("b_p2hit", 12'd609, 12'd418, 12'd0, 12'd419, 4'd0, 4'd0, 2'd1);
    ticks(1, 4'b0000);
    check_all("b_left", 12'd607, 12'd416, 12'd0, 12'd419, 4'd0, 4'd0, 2'd1);
    ticks(285, 4'b0000);
    check_all("b_x37", 12'd37, 12'd154, 12'd0, 12'd419, 4'd0, 4'd0, 2'd1);
    ticks(1, 4'b0000);
    check_all("b_p1miss", 12'd35, 12'd156, 12'd0, 12'd419, 4'd0, 4'd0, 2'd1);
    ticks(18, 4'b0000);
    check_all("b_goal", 12'd317, 12'd237, 12'd0, 12'd419, 4'd0, 4'd1, 2'd2);
    ticks(59, 4'b0100);
    check_all("b_pause59", 12'd317, 12'd237, 12'd236, 12'd419, 4'd0, 4'd1, 2'd2);
    ticks(1, 4'b0100);
    check_all("b_pause60", 12'd317, 12'd237, 12'd240, 12'd419, 4'd0, 4'd1, 2'd1);
    ticks(40, 4'b0100);
    check_all("b_drift", 12'd237, 12'd317, 12'd400, 12'd419, 4'd0, 4'd1, 2'd1);
    ticks(100, 4'b0000);
    check_all("b_n140", 12'd37, 12'd432, 12'd400, 12'd419, 4'd0, 4'd1, 2'd1);
    ticks(1, 4'b0000);
    check_all("b_p1hit", 12'd37, 12'd430, 12'd400, 12'd419, 4'd0, 4'd1, 2'd1);
    ticks(1, 4'b0000);
    check_all("b_right", 12'd39, 12'd428, 12'd400, 12'd419, 4'd0, 4'd1, 2'd1);
    do_reset();
    check_all("b_reset_play", 12'd317, 12'd237, 12'd210, 12'd210, 4'd0, 4'd0, 2'd0);

    // Rally C: nine right goals, each 159 ticks, ending in OVER.
    cycle(1'b1, 1'b0, 4'b0000);
    for (int r = 1; r <= 8; r++) begin
      ticks(159, 4'b0000);
      check_all($sformatf("c_goal%0d", r), 12'd317, 12'd237, 12'd210, 12'd210,
                4'(r), 4'd0, 2'd2);
      ticks(60, 4'b0000);
      check({$sformatf("c_resume%0d", r), ".state"}, {10'd0, bus.state}, 12'd1);
    end
    ticks(10, 4'b0100);
    ticks(149, 4'b0000);
    check_all("c_over", 12'd317, 12'd237, 12'd250, 12'd210, 4'd9, 4'd0, 2'd3);
    ticks(5, 4'b1001);
    check_all("c_frozen", 12'd317, 12'd237, 12'd250, 12'd210, 4'd9, 4'd0, 2'd3);
    cycle(1'b1, 1'b0, 4'b0000);
    check_all("c_restart", 12'd317, 12'd237, 12'd210, 12'd210, 4'd0, 4'd0, 2'd0);

    // Reset while in POINT, then a fresh serve moves down-right again.
    cycle(1'b1, 1'b0, 4'b0000);
    ticks(5, 4'b0000);
    check_all("d_play", 12'd327, 12'd247, 12'd210, 12'd210, 4'd0, 4'd0, 2'd1);
    ticks(154, 4'b0000);
    check_all("d_goal", 12'd317, 12'd237, 12'd210, 12'd210, 4'd1, 4'd0, 2'd2);
    ticks(10, 4'b0000);
    do_reset();
    check_all("d_reset_point", 12'd317, 12'd237, 12'd210, 12'd210, 4'd0, 4'd0, 2'd0);
    cycle(1'b1, 1'b0, 4'b0000);
    ticks(1, 4'b0000);
    check_all("d_after", 12'd319, 12'd239, 12'd210, 12'd210, 4'd0, 4'd0, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-state sequencer for the Pong datapath. Once per video frame it advances the ball, moves both paddles from player inputs, resolves wall and paddle collisions, and keeps score. Its registered position outputs drive the pixel colour generator in place of the fixed initial coordinates. All geometry uses 12-bit pixel coordinates on a 640x480 frame.

## Interface

- BALL_SIZE, 5: ball spans x..x+5, y..y+5
- PLAYER_HEIGHT, 60: paddle spans y..y+60
- PLAYER_WIDTH, 12: paddle spans x..x+12
- PLAYER_1_X, 24; PLAYER_2_X, 615: paddle left edges
- PLAYER_STEP, 4: paddle pixels per frame
- BALL_STEP, 2: ball pixels per frame per axis
- WIN_SCORE, 9: score that ends the game
- PAUSE_FRAMES, 60: frames held in POINT

Ports:

- CLOCK_25  in  1  pixel clock. Single clock domain.
- RESET_N  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per frame. This is the only update strobe.
- p1_up, p1_down, p2_up, p2_down  in  1 each  level inputs, sampled on frame_tick.
- serve  in  1  pulse that starts play or restarts after game over.
- ball_x, ball_y  out  12  ball top-left corner.
- p1_y, p2_y  out  12  paddle top edges.
- score1, score2  out  4  points.
- state  out  2  IDLE=00, PLAY=01, POINT=10, OVER=11.

## Operation

- Reset values, applied on any edge with RESET_N=0, including mid-game:
  - ball_x=317, ball_y=237, p1_y=p2_y=210.
  - Scores 0, state IDLE.
  - Direction dx=right, dy=down. Pause counter 0.
- Paddles update on frame_tick in IDLE, PLAY and POINT. They are frozen in OVER.
  - up&&!down: y=max(y−STEP,0).
  - down&&!up: y=min(y+STEP,419), where 419 = 479−PLAYER_HEIGHT.
  - Both or neither pressed: hold.
- IDLE: ball held at 317/237.
  - serve → PLAY with dx=right, dy=down.
- PLAY, on each frame_tick:
  - Collisions are evaluated against paddle values registered before the tick.
  - Vertical:
    - Moving down and y+STEP ≥ 474: y=474, dy=up.
    - Moving up and y ≤ STEP: y=0, dy=down.
    - Otherwise y ±= STEP.
  - Overlap with a paddle means ball_y+5 ≥ p_y and ball_y ≤ p_y+60.
  - Left side, checked in priority order:
    - P1 hit: dx=left, x ≥ 37, x−STEP ≤ 36, overlap with p1. Result: x=37, dx=right.
    - Goal: dx=left, x ≤ STEP. Result: score2++.
    - Otherwise x −= STEP.
  - Right side, checked in priority order:
    - P2 hit: dx=right, x ≤ 609, x+STEP ≥ 610, overlap with p2. Result: x=609, dx=left.
    - Goal: dx=right, x+STEP ≥ 634. Result: score1++.
    - Otherwise x += STEP.
  - After a goal:
    - Ball returns to 317/237.
    - dx points toward the conceding player; dy is kept.
    - Pause counter is cleared.
    - State becomes OVER if the new score equals WIN_SCORE, else POINT.
- POINT: ball held. Each frame_tick increments the counter. At PAUSE_FRAMES ticks, go to PLAY.
- OVER: all outputs held.
  - serve → IDLE with scores 0, paddles 210, ball reset.
- serve is ignored in PLAY and POINT.

## Timing

- All outputs are registered. Values change on the CLOCK_25 edge that samples frame_tick=1 and are visible the following cycle.
- Outputs are stable between ticks.
- A serve-driven transition occurs on the edge sampling serve, independent of frame_tick.
- If serve and frame_tick are both high in IDLE:
  - Go to PLAY; the ball does not move that cycle.
  - Paddles still update.
- If a vertical wall bounce and a horizontal paddle hit or goal occur on the same tick, both apply. A goal overrides the vertical result by resetting the ball to 317/237.
- Both paddle hit and goal true on the same tick: the hit wins.
- Scores do not increment past WIN_SCORE.

## Test plan

- Reset, serve, 1 frame_tick → ball 319/239, state PLAY. 10 more ticks → ball 339/259.
- Ball at y=473 moving down, tick → y=474, dy=up. Next tick → y=472.
- p1_y=210, ball 38/240 moving left, tick → x=37, dx=right. Repeat with p1_y=0 → no hit; ball continues until x ≤ 2, then score2=1, state POINT, ball 317/237, dx=left. After 60 ticks → PLAY.
- Hold p1_up from 210: after 52 ticks p1_y=2, tick 53 → 0, stays 0. Hold p2_down → p2_y saturates at 419. Both pressed → no change.
- score1=8, right goal → score1=9, state OVER, outputs frozen across ticks. serve → IDLE, scores 0.
- Assert RESET_N=0 for one cycle during PLAY and POINT → all outputs return to reset values the next cycle.
